// File: rtl/addsub_seq16_if.sv
// rtl/addsub_seq16_if.sv - start/done operand and result bundle for addsub_seq16
interface addsub_seq16_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovfl;
    logic         zero;

    modport master (
        output start, a, b, sub,
        input  busy, done, result, cout, ovfl, zero
    );

    modport slave (
        input  start, a, b, sub,
        output busy, done, result, cout, ovfl, zero
    );
endinterface

// File: rtl/addsub_seq16.sv
// rtl/addsub_seq16.sv - nibble-serial add/subtract, LSB nibble first, registered carry
// Optional result saturation on signed overflow: define ADDSUB_SAT_EN
module addsub_seq16 #(
    parameter int NIBBLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    addsub_seq16_if.slave  bus
);
    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] op_a, op_b, partial, part_nxt, res_fin;
    logic [W-1:0] result_q;
    logic         carry, cout_q, ovfl_q, zero_q;
    logic [2:0]   idx;
    logic [3:0]   nib_a, nib_b;
    logic [4:0]   nib_sum;
    logic         c3, ovfl_raw, last, accept, busy_c, done_c;

    always_comb begin
        nib_a    = op_a[{idx, 2'b00} +: 4];
        nib_b    = op_b[{idx, 2'b00} +: 4];
        nib_sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
        // carry into bit 3 recovered from the sum bit and its two operand bits
        c3       = nib_a[3] ^ nib_b[3] ^ nib_sum[3];
        ovfl_raw = c3 ^ nib_sum[4];
        last     = (idx == 3'(NIBBLES - 1));
        part_nxt = partial;
        part_nxt[{idx, 2'b00} +: 4] = nib_sum[3:0];
`ifdef ADDSUB_SAT_EN
        if (ovfl_raw)
            res_fin = op_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            res_fin = part_nxt;
`else
        res_fin = part_nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last)
                    state_nxt = FIN;
            end
            FIN: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            partial  <= '0;
            carry    <= 1'b0;
            idx      <= 3'd0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovfl_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            op_a    <= bus.a;
            op_b    <= bus.b ^ {W{bus.sub}};
            carry   <= bus.sub;
            idx     <= 3'd0;
            partial <= '0;
        end else if (state == RUN) begin
            partial <= part_nxt;
            carry   <= nib_sum[4];
            idx     <= idx + 3'd1;
            // flags and result land on the same edge that enters FIN
            if (last) begin
                result_q <= res_fin;
                cout_q   <= nib_sum[4];
                ovfl_q   <= ovfl_raw;
                zero_q   <= (res_fin == '0);
            end
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovfl   = ovfl_q;
    assign bus.zero   = zero_q;
endmodule
